vga_rx_monitor: RTL and testbench
=================================

Name: vga_rx_monitor

Overview:
- Sink for the TinyVGA PMOD bus driven by the team's VGA demo tops: decodes the packed 8-bit output back into sync timing, pixel coordinates and 6-bit colour.
- Checks timing against 640x480@60 and a blank-time black rule, and produces a per-frame pixel signature.
- Used as an on-chip loopback checker and as the scoreboard front-end in the team's VGA benches.

Parameters:
H_TOTAL, 800, clocks per line
H_START, 144, clocks from hsync falling edge to first active pixel (96 sync + 48 back porch)
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_START, 34, line count (vc) after the vsync-aligned line that carries y=0
V_ACTIVE, 480, active lines per frame
LOCK_FRAMES, 2, consecutive clean frames required to assert locked

Ports:
clk  in  1  pixel clock, same domain as the generator
rst_n  in  1  asynchronous active-low reset
vga_in  in  8  packed bus {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}; syncs are active-low
pix_valid  out  1  active pixel on pix_x/pix_y/pix_rgb this cycle
pix_x  out  10  column 0..639
pix_y  out  10  row 0..479
pix_rgb  out  6  {R[1:0],G[1:0],B[1:0]}, reassembled MSB/LSB
frame_done  out  1  one-cycle pulse at each vsync falling edge
frame_sig  out  16  signature of the last completed frame, held until the next frame_done
locked  out  1  timing matches parameters for LOCK_FRAMES consecutive frames
blank_err  out  1  sticky: non-black colour seen outside the active window while locked
err_count  out  8  saturating count of timing mismatches

Behaviour:
- Input stage: vga_in is registered once (r1), then once more for edge detection (r2). hs_fall = r2.hsync & ~r1.hsync; vs_fall is defined the same way on vsync.
- Horizontal counter hc (10b):
  - On hs_fall: hc <= 0, and the previous hc+1 is compared to H_TOTAL.
  - Otherwise hc increments, saturating at 1023.
- Vertical counter vc (10b):
  - vs_fall sets vs_pend.
  - The next hs_fall with vs_pend set: vc <= 0, vs_pend clears, and the previous vc+1 is compared to V_TOTAL.
  - Any other hs_fall increments vc, saturating at 1023.
- Active window: H_START <= hc < H_START+H_ACTIVE and V_START <= vc < V_START+V_ACTIVE, evaluated on the r1 sample.
- Pixel outputs are registered:
  - pix_valid/pix_x/pix_y/pix_rgb appear 2 clocks after the pixel is on vga_in.
  - pix_x = hc-H_START and pix_y = vc-V_START.
  - pix_x/pix_y/pix_rgb are held when pix_valid=0.
- Signature: sig_acc <= {sig_acc[14:0], sig_acc[15]^sig_acc[13]} ^ {10'b0, rgb} on every active pixel.
- Frame end, on vs_fall in the same cycle:
  - frame_sig <= sig_acc, sig_acc <= 0, frame_done=1.
  - An active pixel in that same cycle is folded before the capture.
- Timing check:
  - Line mismatch: the first hs_fall after reset is not checked.
  - Frame mismatch: the first vc reset after reset is not checked.
  - Each mismatch increments err_count (saturating at 255) and marks the current frame bad.
- Lock FSM, states UNLOCKED, TRACKING, LOCKED:
  - UNLOCKED -> TRACKING on the first vs_fall.
  - TRACKING: the clean-frame counter increments on each vs_fall of a clean frame and clears on any mismatch. At LOCK_FRAMES clean frames -> LOCKED.
  - LOCKED -> UNLOCKED immediately on any mismatch.
  - locked = (state==LOCKED).
- Blank check: blank_err sets when locked=1, the sample is outside the active window, and rgb != 0. It clears only on reset.
- Simultaneous mismatch and vs_fall: the mismatch wins, so no lock and the clean count is 0.
- Reset mid-frame (any time):
  - all counters, sig_acc and frame_sig go to 0; all outputs go to 0; the FSM goes to UNLOCKED and vs_pend clears.
  - Re-lock takes LOCK_FRAMES+1 vs_falls.

Test Plan:
- Drive the team's 640x480 generator with a constant RGB of 6'b11_10_00 for 4 frames:
  - locked rises at the 3rd vs_fall and err_count stays 0.
  - pix_valid is high for 307200 cycles per frame.
  - The first pix_valid has x=0, y=0, rgb=6'b111000.
- Same stream with rgb=0 everywhere except pixel (639,479)=6'b000001:
  - frame_sig equals the golden model value.
  - pix_x=639 and pix_y=479 on that pixel.
  - blank_err stays 0.
- Shorten one line to 799 clocks while locked:
  - err_count increments by 1 and locked drops at the next clock.
  - Re-lock happens 2 clean frames later.
- Inject rgb=6'b000011 during horizontal front porch while locked: blank_err sets and stays set until rst_n low.
- Pulse rst_n low for 3 cycles mid-line on frame 2: all outputs read 0, and locked returns after 3 further vs_falls.
- Hold hsync high continuously: hc saturates at 1023, no pix_valid, locked stays 0, and err_count stays unchanged.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
//   Receiver for the TinyVGA PMOD bus. It recovers sync timing, pixel
//   coordinates and 6-bit colour from the packed 8-bit bus. It checks line and
//   frame lengths against the parameters, flags non-black colour during blanking
//   once locked, and produces a per-frame pixel signature.
//
//   Lock FSM states:
//     state       | meaning
//     UNLOCKED    | no frame reference yet, or a timing mismatch dropped lock
//     TRACKING    | counting consecutive clean frames toward LOCK_FRAMES
//     LOCKED      | timing matched for LOCK_FRAMES consecutive frames
//
// Ports:
//   clk        in   pixel clock (same domain as the generator)
//   rst_n      in   asynchronous active-low reset
//   vga_in     in   {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}, syncs active-low
//   pix_valid  out  active pixel present on pix_x/pix_y/pix_rgb
//   pix_x      out  column of the active pixel
//   pix_y      out  row of the active pixel
//   pix_rgb    out  {R[1:0], G[1:0], B[1:0]}
//   frame_done out  one-cycle pulse at each vsync falling edge
//   frame_sig  out  signature of the last completed frame
//   locked     out  timing lock indication
//   blank_err  out  sticky: colour outside the active window while locked
//   err_count  out  saturating count of line/frame length mismatches
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_START     = 34,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic        locked,
  output logic        blank_err,
  output logic [7:0]  err_count
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_TRACKING = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [9:0]  H_LO   = 10'(H_START);
  localparam logic [9:0]  H_HI   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO   = 10'(V_START);
  localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic [7:0]  r1;
  logic        hs_d, vs_d;
  logic        hs_fall, vs_fall;
  logic [9:0]  hc, vc;
  logic [9:0]  hc_inc, vc_inc, hc_cur, vc_cur;
  logic        vs_pend, vc_rst;
  logic        line_chk_en, frame_chk_en, frame_bad;
  logic        line_mm, frame_mm, mismatch;
  logic        active;
  logic [5:0]  rgb;
  logic [15:0] sig_acc, sig_next;
  logic [8:0]  err_sum;
  logic [7:0]  err_next;
  logic [1:0]  state;
  logic [3:0]  clean_cnt;

  // r1 holds the current sample; only the sync bits are needed one stage later.
  assign hs_fall = hs_d & ~r1[7];
  assign vs_fall = vs_d & ~r1[3];
  assign rgb     = {r1[0], r1[4], r1[1], r1[5], r1[2], r1[6]};
  assign locked  = (state == ST_LOCKED);

  // hc_cur/vc_cur are the coordinates of the sample now in r1; the registered
  // hc/vc trail by one, so hc+1 at an hs_fall is the length of the line just ended.
  always_comb begin
    hc_inc = (hc == 10'd1023) ? hc : hc + 10'd1;
    vc_inc = (vc == 10'd1023) ? vc : vc + 10'd1;
    vc_rst = hs_fall & vs_pend;
    hc_cur = hs_fall ? 10'd0 : hc_inc;
    vc_cur = vc;
    if (hs_fall) vc_cur = vs_pend ? 10'd0 : vc_inc;
    active = (hc_cur >= H_LO) && (hc_cur < H_HI) && (vc_cur >= V_LO) && (vc_cur < V_HI);
    line_mm  = hs_fall & line_chk_en & (({1'b0, hc} + 11'd1) != H_TOT);
    frame_mm = vc_rst & frame_chk_en & (({1'b0, vc} + 11'd1) != V_TOT);
    mismatch = line_mm | frame_mm;
    sig_next = sig_acc;
    if (active) sig_next = {sig_acc[14:0], sig_acc[15] ^ sig_acc[13]} ^ {10'b0, rgb};
    err_sum  = {1'b0, err_count} + {8'b0, line_mm} + {8'b0, frame_mm};
    err_next = err_sum[8] ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1           <= 8'h00;
      hs_d         <= 1'b0;
      vs_d         <= 1'b0;
      hc           <= 10'd0;
      vc           <= 10'd0;
      vs_pend      <= 1'b0;
      line_chk_en  <= 1'b0;
      frame_chk_en <= 1'b0;
      frame_bad    <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= 10'd0;
      pix_y        <= 10'd0;
      pix_rgb      <= 6'd0;
      sig_acc      <= 16'd0;
      frame_sig    <= 16'd0;
      frame_done   <= 1'b0;
      err_count    <= 8'd0;
      blank_err    <= 1'b0;
      state        <= ST_UNLOCKED;
      clean_cnt    <= 4'd0;
    end else begin
      r1   <= vga_in;
      hs_d <= r1[7];
      vs_d <= r1[3];
      hc   <= hc_cur;
      vc   <= vc_cur;

      // A vsync fall coinciding with the consuming hs_fall re-arms for the next one.
      if (vc_rst)  vs_pend <= 1'b0;
      if (vs_fall) vs_pend <= 1'b1;

      // The first line and first frame after reset are partial, so they arm the checks.
      if (hs_fall) line_chk_en  <= 1'b1;
      if (vc_rst)  frame_chk_en <= 1'b1;

      pix_valid <= active;
      if (active) begin
        pix_x   <= hc_cur - H_LO;
        pix_y   <= vc_cur - V_LO;
        pix_rgb <= rgb;
      end

      frame_done <= vs_fall;
      if (vs_fall) begin
        frame_sig <= sig_next;
        sig_acc   <= 16'd0;
      end else begin
        sig_acc   <= sig_next;
      end

      err_count <= err_next;

      if (locked && !active && (rgb != 6'd0)) blank_err <= 1'b1;

      if (vs_fall)       frame_bad <= 1'b0;
      else if (mismatch) frame_bad <= 1'b1;

      case (state)
        ST_UNLOCKED: begin
          clean_cnt <= 4'd0;
          if (vs_fall) state <= ST_TRACKING;
        end
        ST_TRACKING: begin
          if (mismatch) begin
            clean_cnt <= 4'd0;
          end else if (vs_fall && !frame_bad) begin
            if (clean_cnt + 4'd1 >= LOCK_N) begin
              state     <= ST_LOCKED;
              clean_cnt <= 4'd0;
            end else begin
              clean_cnt <= clean_cnt + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            state     <= ST_UNLOCKED;
            clean_cnt <= 4'd0;
          end
        end
        default: begin
          state     <= ST_UNLOCKED;
          clean_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor using a scaled-down raster so whole frames stay short:
// 20 clocks/line (2 sync, 3 back porch, 10 active, 5 front porch) and
// 12 lines/frame (2 vsync lines, vc 0..2 blank, vc 3..8 active, vc 9..10 blank).
module tb_vga_rx_monitor;
  localparam int HT = 20, HS = 5, HA = 10, VT = 12, VS = 3, VA = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic        frame_done;
  logic [15:0] frame_sig;
  logic        locked;
  logic        blank_err;
  logic [7:0]  err_count;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_sig(frame_sig), .locked(locked),
    .blank_err(blank_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, fd_count = 0, pv_count = 0, last_pv = 0;
  int lock_frame = -1, unlock_cyc = -1, mark_cyc = -1;
  logic prev_locked = 1'b0;
  logic first_seen = 1'b0;
  logic [9:0] fx = '0, fy = '0, nz_x = '0, nz_y = '0;
  logic [5:0] frgb = '0;
  logic rec_nz = 1'b0;
  logic rst_nonzero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pat(input int m, input int x, input int y);
    case (m)
      0:       return 6'b111000;
      1:       return (x == 9 && y == 5) ? 6'b000001 : 6'b000000;
      default: return 6'((x + 3 * y) & 63);
    endcase
  endfunction

  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s = 16'd0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        s = {s[14:0], s[15] ^ s[13]} ^ {10'b0, pat(m, x, y)};
    return s;
  endfunction

  // One clock: sample outputs at the falling edge, then drive the next inputs.
  task automatic cycle(input logic [7:0] v, input logic r);
    @(negedge clk);
    cyc++;
    if (frame_done) begin
      fd_count++;
      last_pv  = pv_count;
      pv_count = 0;
    end
    if (pix_valid) begin
      pv_count++;
      if (!first_seen) begin
        first_seen = 1'b1;
        fx = pix_x; fy = pix_y; frgb = pix_rgb;
      end
      if (rec_nz && pix_rgb != 6'd0) begin
        nz_x = pix_x; nz_y = pix_y;
      end
    end
    if (locked && !prev_locked) lock_frame = fd_count;
    if (!locked && prev_locked) unlock_cyc = cyc;
    prev_locked = locked;
    if (!rst_n && (|{pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_sig,
                     locked, blank_err, err_count})) rst_nonzero = 1'b1;
    rst_n  = r;
    vga_in = v;
  endtask

  // short_l: line shortened by one clock; inj_l: line with front-porch colour;
  // rst_l: line with a 3-clock reset pulse. -1 disables each.
  task automatic gen_frame(input int m, input int short_l, input int inj_l, input int rst_l);
    logic [5:0] c6;
    logic hs, vs, act;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < ((l == short_l) ? HT - 1 : HT); c++) begin
        hs  = (c >= 2);
        vs  = (l >= 2);
        act = (l >= 4) && (l < 4 + VA) && (c >= HS) && (c < HS + HA);
        if (act)                        c6 = pat(m, c - HS, l - 4);
        else if (l == inj_l && c == 16) c6 = 6'b000011;
        else                            c6 = 6'd0;
        cycle({hs, c6[0], c6[2], c6[4], vs, c6[1], c6[3], c6[5]},
              !(l == rst_l && c >= 8 && c <= 10));
        if (l == short_l + 1 && c == 0) mark_cyc = cyc;
      end
    end
  endtask

  int f0;

  initial begin
    // Reset state
    repeat (3) cycle(8'h88, 1'b0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_xy",    32'({pix_x, pix_y}), 32'd0);
    chk("rst_pix_rgb",   32'(pix_rgb), 32'd0);
    chk("rst_frame",     32'({frame_done, frame_sig}), 32'd0);
    chk("rst_status",    32'({locked, blank_err, err_count}), 32'd0);
    repeat (4) cycle(8'h88, 1'b1);

    // Constant colour, four frames: lock at the 3rd vsync fall
    for (int i = 0; i < 4; i++) gen_frame(0, -1, -1, -1);
    chk("lock_frame",     32'(lock_frame), 32'd3);
    chk("locked_after4",  32'(locked), 32'd1);
    chk("err_after4",     32'(err_count), 32'd0);
    chk("pv_per_frame",   32'(last_pv), 32'(HA * VA));
    chk("pv_frame4",      32'(pv_count), 32'(HA * VA));
    chk("first_xy",       32'({fx, fy}), 32'd0);
    chk("first_rgb",      32'(frgb), 32'b111000);
    chk("sig_const",      32'(frame_sig), 32'(model_sig(0)));

    // Single lit pixel at the last active position
    rec_nz = 1'b1;
    gen_frame(1, -1, -1, -1);
    rec_nz = 1'b0;
    chk("held_valid_low", 32'(pix_valid), 32'd0);
    chk("held_x",         32'(pix_x), 32'(HA - 1));
    chk("held_y",         32'(pix_y), 32'(VA - 1));
    chk("held_rgb",       32'(pix_rgb), 32'b000001);
    chk("nz_x",           32'(nz_x), 32'(HA - 1));
    chk("nz_y",           32'(nz_y), 32'(VA - 1));
    gen_frame(0, -1, -1, -1);
    chk("sig_single",     32'(frame_sig), 32'h0001);
    chk("blank_clean",    32'(blank_err), 32'd0);

    // Varying pattern signature
    gen_frame(2, -1, -1, -1);
    gen_frame(0, -1, -1, -1);
    chk("sig_ramp",       32'(frame_sig), 32'(model_sig(2)));

    // Short line while locked
    gen_frame(0, 5, -1, -1);
    chk("short_err",      32'(err_count), 32'd1);
    chk("short_unlock",   32'(locked), 32'd0);
    chk("unlock_latency", 32'(unlock_cyc), 32'(mark_cyc + 2));
    f0 = fd_count;
    gen_frame(0, -1, -1, -1);
    gen_frame(0, -1, -1, -1);
    chk("relock_not_early", 32'(locked), 32'd0);
    gen_frame(0, -1, -1, -1);
    chk("relock",         32'(locked), 32'd1);
    chk("relock_frame",   32'(lock_frame), 32'(f0 + 3));
    chk("relock_err",     32'(err_count), 32'd1);

    // Front-porch colour while locked
    gen_frame(0, -1, 5, -1);
    chk("blank_set",      32'(blank_err), 32'd1);
    gen_frame(0, -1, -1, -1);
    chk("blank_sticky",   32'(blank_err), 32'd1);
    chk("blank_locked",   32'({locked, err_count}), 32'({1'b1, 8'd1}));

    // Reset mid-line
    gen_frame(0, -1, -1, 6);
    chk("midrst_zero",    32'(rst_nonzero), 32'd0);
    chk("midrst_status",  32'({locked, blank_err, err_count}), 32'd0);
    chk("midrst_sig",     32'(frame_sig), 32'd0);
    f0 = fd_count;
    for (int i = 0; i < 3; i++) gen_frame(0, -1, -1, -1);
    chk("midrst_relock",  32'(lock_frame), 32'(f0 + 3));
    chk("midrst_locked",  32'(locked), 32'd1);
    chk("midrst_err",     32'({blank_err, err_count}), 32'd0);

    // hsync held high from reset
    repeat (3) cycle(8'hff, 1'b0);
    pv_count = 0;
    f0 = fd_count;
    repeat (1100) cycle(8'hff, 1'b1);
    chk("hold_hc_sat",    32'(dut.hc), 32'd1023);
    chk("hold_no_pv",     32'(pv_count), 32'd0);
    chk("hold_unlocked",  32'(locked), 32'd0);
    chk("hold_err",       32'(err_count), 32'd0);
    chk("hold_no_frame",  32'(fd_count), 32'(f0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
